// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: drives the core's inst bus through the per-kij sequence
// (weights into L0 and the array, activations into L0 and execute, drain, psum
// write-back). Every output is registered and encodes the state entered on
// that same clock edge.
module core_inst_sequencer #(
    parameter int unsigned COL       = 8,
    parameter int unsigned ROW       = 8,
    parameter int unsigned DRAIN_CYC = 10,
    parameter int unsigned AW        = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       num_kij,
    input  logic [AW-1:0]    len_nij,
    input  logic [AW-1:0]    w_base,
    input  logic [AW-1:0]    a_base,
    input  logic [AW-1:0]    p_base,
    output logic [2*AW+11:0] inst,
    output logic             busy,
    output logic             done
);

    // One extra bit so the counter can reach len_nij inclusive.
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = 2 * AW + 12;

    localparam logic [CW-1:0] WreadLast = CW'(COL);
    localparam logic [CW-1:0] WloadLast = CW'(COL + ROW - 1);
    localparam logic [CW-1:0] DrainLast = CW'(DRAIN_CYC - 1);

    // Both SRAMs disabled (active-low CEN/WEN high), addresses and strobes 0.
    localparam logic [IW-1:0] IdleInst = {1'b0, 1'b1, 1'b1, {AW{1'b0}},
                                          1'b1, 1'b1, {AW{1'b0}}, 7'b0};

    typedef enum logic [2:0] {
        StIdle, StWread, StWload, StAread, StExec, StDrain, StPsum, StDone
    } state_e;

    state_e          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic [3:0]      r_kij, w_kij_d;
    logic [3:0]      r_num_kij, w_num_kij_d;
    logic [AW-1:0]   r_len, w_len_d;
    logic [AW-1:0]   r_w_base, w_w_base_d;
    logic [AW-1:0]   r_a_base, w_a_base_d;
    logic [AW-1:0]   r_p_base, w_p_base_d;
    logic [IW-1:0]   r_inst, w_inst_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;

    logic [CW-1:0]   w_len_ext;
    logic [CW-1:0]   w_len_d_ext;
    logic [AW-1:0]   w_cnt_a;
    logic [AW-1:0]   w_kij_ofs;

    // Instruction fields for the upcoming cycle.
    logic            w_acc, w_cen_p, w_wen_p, w_cen_x, w_wen_x;
    logic [AW-1:0]   w_a_p, w_a_x;
    logic            w_ofifo_rd, w_l0_rd, w_l0_wr, w_exec, w_load;

    assign w_len_ext   = {1'b0, r_len};
    assign w_len_d_ext = {1'b0, w_len_d};

    // Next-state, counter, kij and config-latch logic.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt + CW'(1);
        w_kij_d     = r_kij;
        w_num_kij_d = r_num_kij;
        w_len_d     = r_len;
        w_w_base_d  = r_w_base;
        w_a_base_d  = r_a_base;
        w_p_base_d  = r_p_base;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                w_kij_d = '0;
                if (start) begin
                    w_num_kij_d = num_kij;
                    w_len_d     = len_nij;
                    w_w_base_d  = w_base;
                    w_a_base_d  = a_base;
                    w_p_base_d  = p_base;
                    if (num_kij == 4'd0 || len_nij == '0) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d = StWread;
                    end
                end
            end
            StWread: begin
                if (r_cnt == WreadLast) begin
                    w_state_d = StWload;
                    w_cnt_d   = '0;
                end
            end
            StWload: begin
                if (r_cnt == WloadLast) begin
                    w_state_d = StAread;
                    w_cnt_d   = '0;
                end
            end
            StAread: begin
                if (r_cnt == w_len_ext) begin
                    w_state_d = StExec;
                    w_cnt_d   = '0;
                end
            end
            StExec: begin
                if (r_cnt == w_len_ext - CW'(1)) begin
                    w_state_d = StDrain;
                    w_cnt_d   = '0;
                end
            end
            StDrain: begin
                if (r_cnt == DrainLast) begin
                    w_state_d = StPsum;
                    w_cnt_d   = '0;
                end
            end
            StPsum: begin
                if (r_cnt == w_len_ext) begin
                    w_cnt_d = '0;
                    if (r_kij == r_num_kij - 4'd1) begin
                        w_state_d = StDone;
                    end else begin
                        w_kij_d   = r_kij + 4'd1;
                        w_state_d = StWread;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign w_cnt_a   = w_cnt_d[AW-1:0];
    assign w_kij_ofs = AW'(w_kij_d) * AW'(COL);

    // Decode the instruction word for the state being entered.
    always_comb begin
        w_acc      = 1'b0;
        w_cen_p    = 1'b1;
        w_wen_p    = 1'b1;
        w_a_p      = '0;
        w_cen_x    = 1'b1;
        w_wen_x    = 1'b1;
        w_a_x      = '0;
        w_ofifo_rd = 1'b0;
        w_l0_rd    = 1'b0;
        w_l0_wr    = 1'b0;
        w_exec     = 1'b0;
        w_load     = 1'b0;
        case (w_state_d)
            StWread: begin
                if (w_cnt_d < CW'(COL)) begin
                    w_cen_x = 1'b0;
                    w_a_x   = w_w_base_d + w_kij_ofs + w_cnt_a;
                end
                // L0 captures the xmem data one cycle after the read.
                w_l0_wr = (w_cnt_d != '0);
            end
            StWload: begin
                w_l0_rd = 1'b1;
                w_load  = 1'b1;
            end
            StAread: begin
                if (w_cnt_d < w_len_d_ext) begin
                    w_cen_x = 1'b0;
                    w_a_x   = w_a_base_d + w_cnt_a;
                end
                w_l0_wr = (w_cnt_d != '0);
            end
            StExec: begin
                w_l0_rd = 1'b1;
                w_exec  = 1'b1;
            end
            StPsum: begin
                w_ofifo_rd = (w_cnt_d < w_len_d_ext);
                // pmem write trails each ofifo read by one cycle.
                if (w_cnt_d != '0) begin
                    w_cen_p = 1'b0;
                    w_wen_p = 1'b0;
                    w_a_p   = w_p_base_d + w_cnt_a - AW'(1);
                    w_acc   = (w_kij_d != 4'd0);
                end
            end
            default: ;
        endcase
        w_inst_d = {w_acc, w_cen_p, w_wen_p, w_a_p, w_cen_x, w_wen_x, w_a_x,
                    w_ofifo_rd, 1'b0, 1'b0, w_l0_rd, w_l0_wr, w_exec, w_load};
        w_busy_d = (w_state_d != StIdle) && (w_state_d != StDone);
        w_done_d = (w_state_d == StDone);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_kij     <= '0;
            r_num_kij <= '0;
            r_len     <= '0;
            r_w_base  <= '0;
            r_a_base  <= '0;
            r_p_base  <= '0;
            r_inst    <= IdleInst;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_kij     <= w_kij_d;
            r_num_kij <= w_num_kij_d;
            r_len     <= w_len_d;
            r_w_base  <= w_w_base_d;
            r_a_base  <= w_a_base_d;
            r_p_base  <= w_p_base_d;
            r_inst    <= w_inst_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

endmodule
